// File: rtl/opl2_host_if.sv
// rtl/opl2_host_if.sv - OPL2 host bus to register-write bridge with status reads and busy tracking
package opl2_pkg;
    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;
endpackage

module opl2_host_if
    import opl2_pkg::*;
#(
    parameter int BUSY_ADDR_CYCLES = 235,
    parameter int BUSY_DATA_CYCLES = 1643
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs_n,
    input  logic         rd_n,
    input  logic         wr_n,
    input  logic         a0,
    input  logic [7:0]   din,
    output logic [7:0]   dout,
    input  logic         irq,
    input  logic         ft1,
    input  logic         ft2,
    output opl2_reg_wr_t opl2_reg_wr,
    output logic         busy,
    output logic         busy_err
);
    localparam int MAX_CYCLES = (BUSY_ADDR_CYCLES > BUSY_DATA_CYCLES) ? BUSY_ADDR_CYCLES
                                                                      : BUSY_DATA_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    logic          wr_act;
    logic          rd_act;
    logic          wr_prev;
    logic          rd_prev;
    logic          wr_edge;
    logic          rd_edge;
    logic [7:0]    addr_latch;
    logic [CW-1:0] busy_cnt;

    assign wr_act  = !cs_n && !wr_n;
    assign rd_act  = !cs_n && !rd_n;
    assign wr_edge = wr_act && !wr_prev;
    assign rd_edge = rd_act && !rd_prev;
    assign busy    = (busy_cnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_prev     <= 1'b0;
            rd_prev     <= 1'b0;
            addr_latch  <= 8'h00;
            busy_cnt    <= '0;
            busy_err    <= 1'b0;
            dout        <= 8'h00;
            opl2_reg_wr <= '0;
        end else begin
            wr_prev           <= wr_act;
            rd_prev           <= rd_act;
            opl2_reg_wr.valid <= 1'b0;
            busy_err          <= 1'b0;

            // A write always wins: it reloads the window rather than extending it.
            if (wr_edge) begin
                busy_err <= busy;
                if (a0) begin
                    opl2_reg_wr.valid   <= 1'b1;
                    opl2_reg_wr.address <= addr_latch;
                    opl2_reg_wr.data    <= din;
                    busy_cnt            <= CW'(BUSY_DATA_CYCLES);
                end else begin
                    addr_latch <= din;
                    busy_cnt   <= CW'(BUSY_ADDR_CYCLES);
                end
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
            end

            if (rd_edge && !wr_edge) begin
                dout <= a0 ? 8'hFF : {irq, ft1, ft2, 5'b00110};
            end
        end
    end
endmodule

// File: doc/opl2_host_if.md
# opl2_host_if

Host-side bus interface for the OPL2 core. It converts an ISA/AdLib-style two-port host bus (address port at A0=0, data port at A0=1) into single-cycle `opl2_reg_wr_t` register-write transactions for the register file. It returns the OPL2 status byte on reads and tracks the chip's post-write busy windows so that host-timing violations are flagged. It sits between the host bus (already synchronous to `clk`) and the register file / timer logic.

## Interface

**Parameters**
- `BUSY_ADDR_CYCLES`, default 235: `clk` cycles busy after an address-port write (12 OPL2 master clocks at 70 MHz).
- `BUSY_DATA_CYCLES`, default 1643: `clk` cycles busy after a data-port write (84 OPL2 master clocks at 70 MHz).

**Ports**
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high.
- `cs_n` in 1: chip select, active-low.
- `rd_n` in 1: read strobe, active-low.
- `wr_n` in 1: write strobe, active-low.
- `a0` in 1: port select; 0 = address/status, 1 = data.
- `din` in 8: host write data.
- `dout` out 8: registered host read data.
- `irq` in 1: timer IRQ flag from the timer block.
- `ft1` in 1: timer 1 overflow flag.
- `ft2` in 1: timer 2 overflow flag.
- `opl2_reg_wr` out `opl2_reg_wr_t`: fields are valid, address[7:0], data[7:0].
- `busy` out 1: high while a post-write busy window is active.
- `busy_err` out 1: one-cycle pulse when a host write is accepted while `busy`.

## Operation

- Strobe qualification: `wr_act = !cs_n & !wr_n` and `rd_act = !cs_n & !rd_n`, sampled every `clk`. An access is the rising edge of the sampled signal (previous sample 0, current sample 1). A strobe held for any number of cycles produces exactly one access.
- If `wr_act` and `rd_act` rise in the same cycle, the write is processed and the read is dropped.
- Address write (`a0=0`):
  - Load `din` into the address latch.
  - No `opl2_reg_wr` pulse.
  - Load the busy counter with `BUSY_ADDR_CYCLES`.
- Data write (`a0=1`):
  - Emit `opl2_reg_wr.valid=1` for one cycle, with `address` = the latch value and `data` = the sampled `din`.
  - Load the busy counter with `BUSY_DATA_CYCLES`.
  - The address latch is unchanged, so repeated data writes reuse it.
- Write while `busy`:
  - The write is still fully accepted.
  - The counter is reloaded with the new value, not summed.
  - `busy_err` pulses in the same cycle the write takes effect.
- Read at `a0=0`: `dout` = {`irq`, `ft1`, `ft2`, 5'b00110}, matching YM3812 status.
- Read at `a0=1`: `dout` = 8'hFF.
- Reads have no side effects and do not touch `busy`.
- Busy counter:
  - Width is $clog2 of the larger parameter, plus 1.
  - Decrements by 1 per cycle while nonzero and saturates at 0.
  - `busy` = (counter != 0).

## Timing

- Edge detected in cycle N (the first cycle the sampled strobe is 1):
  - The address latch or `opl2_reg_wr` output is registered at the end of N and visible in N+1.
  - For a data write, valid is high in N+1 only.
- `busy` rises in N+1 and stays high for exactly the loaded count of cycles; it is low again in N+1+count.
- `busy_err` is high in N+1 when `busy` was high in cycle N.
- `dout` updates in N+1 and holds until the next read access.
- Reset values:
  - `opl2_reg_wr` = all zero.
  - Address latch = 8'h00.
  - `dout` = 8'h00.
  - Busy counter = 0.
  - `busy` = 0 and `busy_err` = 0.
  - Strobe history = 0 (inactive).
- Reset mid-busy: the counter clears immediately (asynchronously). A strobe that is still asserted when reset releases counts as a new edge on the first sampled cycle.
- Back-to-back data writes one cycle apart (strobe 1,0,1) produce two valid pulses, each with its own `data`.

## Test plan

- Write 0x20 to A0=0, then 0x21 to A0=1 → exactly one valid pulse with address=0x20, data=0x21, one cycle after the data edge. After the data edge, `busy` stays high for 1643 cycles.
- Hold `wr_n` low for 10 cycles on a data write → exactly one valid pulse.
- Drive `irq`=1, `ft1`=1, `ft2`=0 and read A0=0 → `dout`=0xC6 one cycle after the edge. Read A0=1 → 0xFF.
- Address write, then a data write 5 cycles later → `busy_err` pulses once, the register write is still issued, and `busy` reloads to 1643.
- Assert `reset` mid-window, 100 cycles into `busy` → `busy`=0 and `dout`=0. A following data write with no address write emits address=0x00.
- Raise `wr_act` and `rd_act` in the same cycle with A0=1 and `din`=0x55 → the write is issued and `dout` is unchanged.
